// File: rtl/mssd_pkg.sv
// Shared constants for the multiplexed seven-segment driver: segment
// encodings (active-low, gfedcba) and PWM step count.
package mssd_pkg;

    localparam int PWM_STEPS = 16;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 0 is the rightmost entry.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/mssd_multi_seg7_decode.sv
// Hex nibble to active-low seven-segment pattern (a..g on bits 0..6).
module seg7_decode
    import mssd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_seg(nib);

endmodule

// File: rtl/mssd_multi.sv
// Time-multiplexed common-anode seven-segment driver with double-buffered
// loading, 16-level PWM and per-digit blink. Define MSSD_LZB_EN for leading-zero blanking.
module mssd_multi
    import mssd_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_value,
    input  logic                  load,
    input  logic [N_DIGITS-1:0]   blink_mask,
    input  logic [3:0]            brightness,
    output logic                  pending,
    output logic [6:0]            display,
    output logic                  DP,
    output logic [N_DIGITS-1:0]   AN
);

    localparam int CW        = $clog2(REFRESH_DIV);
    localparam int IW        = $clog2(N_DIGITS);
    localparam int FW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int SLOT_STEP = REFRESH_DIV / PWM_STEPS;

    typedef struct packed {
        logic [N_DIGITS-1:0][3:0] nib;
        logic [N_DIGITS-1:0]      dp;
        logic [N_DIGITS-1:0]      blink;
    } buf_t;

    buf_t in_buf, shadow, active;

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [FW-1:0] fcnt;
    logic          blink_on;
    logic          tick, frame_bnd;

    assign in_buf.nib   = value;
    assign in_buf.dp    = dp_value;
    assign in_buf.blink = blink_mask;

    assign tick      = (cnt == CW'(REFRESH_DIV - 1));
    assign frame_bnd = tick && (idx == IW'(N_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            idx      <= '0;
            fcnt     <= '0;
            blink_on <= 1'b1;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick)
                idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
            if (frame_bnd) begin
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt     <= '0;
                    blink_on <= ~blink_on;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end
        end
    end

    // Active only changes on a frame boundary, so a frame never mixes old and new digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else if (load && frame_bnd) begin
            shadow  <= in_buf;
            active  <= in_buf;
            pending <= 1'b0;
        end else if (load) begin
            shadow  <= in_buf;
            pending <= 1'b1;
        end else if (frame_bnd && pending) begin
            active  <= shadow;
            pending <= 1'b0;
        end
    end

    logic [3:0]          cur_nib;
    logic [6:0]          cur_seg;
    logic [N_DIGITS-1:0] keep;
    logic                pwm_on, lit;

    assign cur_nib = active.nib[idx];

    seg7_decode u_dec (
        .nib (cur_nib),
        .seg (cur_seg)
    );

`ifdef MSSD_LZB_EN
    logic seen;
    // Scan from the top digit down; a digit stays lit once a nonzero nibble has been seen.
    always_comb begin
        seen = 1'b0;
        keep = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            seen    = seen | (active.nib[i] != 4'h0);
            keep[i] = seen | active.dp[i] | (i == 0);
        end
    end
`else
    assign keep = '1;
`endif

    assign pwm_on = 32'(cnt) < (32'(brightness) + 32'd1) * 32'(SLOT_STEP);
    assign lit    = pwm_on && keep[idx] && !(active.blink[idx] && !blink_on);

    always_ff @(posedge clk) begin
        if (rst || !lit) begin
            AN      <= '1;
            display <= SEG_BLANK;
            DP      <= 1'b1;
        end else begin
            AN      <= ~(N_DIGITS'(1) << idx);
            display <= cur_seg;
            DP      <= ~active.dp[idx];
        end
    end

endmodule

// File: tb/tb_mssd_multi.sv
// Directed bench for mssd_multi (4 digits, 16-cycle slots, 2-frame blink).
module tb_mssd_multi;

    localparam int N  = 4;
    localparam int RD = 16;
    localparam int BF = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [4*N-1:0] value;
    logic [N-1:0]   dp_value;
    logic           load;
    logic [N-1:0]   blink_mask;
    logic [3:0]     brightness;
    logic           pending;
    logic [6:0]     display;
    logic           DP;
    logic [N-1:0]   AN;

    int k, n_chk, n_pass, n_lo;

    mssd_multi #(.N_DIGITS(N), .REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_value   (dp_value),
        .load       (load),
        .blink_mask (blink_mask),
        .brightness (brightness),
        .pending    (pending),
        .display    (display),
        .DP         (DP),
        .AN         (AN)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    endtask

    // k = index of the last posedge; outputs then reflect slot state cnt=k%16, idx=(k/16)%4
    task automatic step();
        @(posedge clk);
        k++;
        #2;
    endtask

    task automatic go(input int t);
        while (k < t) step();
    endtask

    // Load is sampled on the posedge of this step (k afterwards = capture edge).
    task automatic ld(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value      = v;
        dp_value   = d;
        blink_mask = b;
        load       = 1'b1;
        step();
        load       = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e,
                           input logic dp_e);
        chk({tag, ".AN"}, 32'(AN), 32'(an_e));
        chk({tag, ".seg"}, 32'(display), 32'(seg_e));
        chk({tag, ".DP"}, 32'(DP), 32'(dp_e));
    endtask

    initial begin
        logic [3:0][6:0] seg1234;
        logic [3:0][6:0] segabcd;
        seg1234 = {7'h79, 7'h24, 7'h30, 7'h19};
        segabcd = {7'h08, 7'h03, 7'h46, 7'h21};
        n_chk = 0; n_pass = 0; k = 0;
        rst = 1'b1; load = 1'b0; value = '0; dp_value = '0; blink_mask = '0; brightness = 4'd15;

        repeat (3) step();
        chk("rst.pending", 32'(pending), 32'd0);
        chk_out("rst", 4'hF, 7'h7F, 1'b1);

        // Scan: load 1234 at P0, committed at the first frame boundary (P63)
        value = 16'h1234; dp_value = 4'b0100; load = 1'b1; rst = 1'b0; k = -1;
        step();
        load = 1'b0;
        chk("scan.pend0", 32'(pending), 32'd1);
        chk_out("scan.k0", 4'b1110, 7'h40, 1'b1);
        go(62);  chk("scan.pend62", 32'(pending), 32'd1);
        go(63);  chk("scan.pend63", 32'(pending), 32'd0);
        chk_out("scan.k63", 4'b0111, 7'h40, 1'b1);
        for (int d = 0; d < 2; d++) begin
            go(64 + 16*d + 5);
            chk_out("scan", ~(4'b0001 << d), seg1234[d], 1'b1);
        end

        // Tear-free: load ABCD mid-frame, old digits finish the frame
        go(90); ld(16'hABCD, 4'b0000, 4'b0000);
        chk("tear.pend", 32'(pending), 32'd1);
        go(101); chk_out("tear.old2", 4'b1011, seg1234[2], 1'b0);
        go(117); chk_out("tear.old3", 4'b0111, seg1234[3], 1'b1);
        go(126); chk("tear.pend126", 32'(pending), 32'd1);
        go(127); chk("tear.pend127", 32'(pending), 32'd0);
        chk_out("tear.k127", 4'b0111, 7'h79, 1'b1);
        for (int d = 0; d < 4; d++) begin
            go(128 + 16*d + 3);
            chk_out("tear.new", ~(4'b0001 << d), segabcd[d], 1'b1);
        end

        // Load on the frame-boundary cycle goes straight to active
        go(190); ld(16'h5678, 4'b0000, 4'b0000);
        chk("sim.pend191", 32'(pending), 32'd0);
        chk_out("sim.k191", 4'b0111, 7'h08, 1'b1);
        step();
        chk("sim.pend192", 32'(pending), 32'd0);
        chk_out("sim.k192", 4'b1110, 7'h00, 1'b1);
        go(208); chk_out("sim.k208", 4'b1101, 7'h78, 1'b1);
        go(250); chk("sim.pend250", 32'(pending), 32'd0);

        // Brightness duty per slot
        go(255); brightness = 4'd3; n_lo = 0;
        repeat (16) begin step(); if (AN[0] == 1'b0) n_lo++; end
        chk("pwm.b3", 32'(n_lo), 32'd4);
        brightness = 4'd0; n_lo = 0;
        repeat (16) begin step(); if (AN[1] == 1'b0) n_lo++; end
        chk("pwm.b0", 32'(n_lo), 32'd1);
        brightness = 4'd15;

        // Blink digit 1: on in frames 4,5; off in 6,7; on in 8
        go(318); ld(16'h1234, 4'b0000, 4'b0010);
        go(340); chk_out("blink.f5d1", 4'b1101, 7'h30, 1'b1);
        go(388); chk_out("blink.f6d0", 4'b1110, 7'h19, 1'b1);
        go(404); chk_out("blink.f6d1", 4'hF, 7'h7F, 1'b1);
        go(420); chk_out("blink.f6d2", 4'b1011, 7'h24, 1'b1);
        go(468); chk_out("blink.f7d1", 4'hF, 7'h7F, 1'b1);
        go(532); chk_out("blink.f8d1", 4'b1101, 7'h30, 1'b1);

        // Mid-frame reset discards a pending shadow
        go(540); ld(16'h9999, 4'hF, 4'h0);
        chk("mrst.pend", 32'(pending), 32'd1);
        rst = 1'b1; step();
        chk("mrst.pend0", 32'(pending), 32'd0);
        chk_out("mrst", 4'hF, 7'h7F, 1'b1);
        rst = 1'b0; k = -1; step();
        chk_out("mrst.k0", 4'b1110, 7'h40, 1'b1);
        go(64); chk_out("mrst.k64", 4'b1110, 7'h40, 1'b1);
        chk("mrst.pend64", 32'(pending), 32'd0);

        // Leading zeros: 0050, then 0000
        go(126); ld(16'h0050, 4'b0000, 4'b0000);
        go(128); chk_out("lz.d0", 4'b1110, 7'h40, 1'b1);
        go(144); chk_out("lz.d1", 4'b1101, 7'h12, 1'b1);
`ifdef MSSD_LZB_EN
        go(160); chk_out("lz.d2", 4'hF, 7'h7F, 1'b1);
        go(176); chk_out("lz.d3", 4'hF, 7'h7F, 1'b1);
`else
        go(160); chk_out("lz.d2", 4'b1011, 7'h40, 1'b1);
        go(176); chk_out("lz.d3", 4'b0111, 7'h40, 1'b1);
`endif
        go(190); ld(16'h0000, 4'b0000, 4'b0000);
        go(192); chk_out("lz0.d0", 4'b1110, 7'h40, 1'b1);
`ifdef MSSD_LZB_EN
        go(208); chk_out("lz0.d1", 4'hF, 7'h7F, 1'b1);
`else
        go(208); chk_out("lz0.d1", 4'b1101, 7'h40, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
